// File: rtl/mdu_pkg.sv
// Shared MDU encodings and default latencies for the multiply/divide unit.
package mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'b0000,
    MDU_MULT  = 4'b0001,
    MDU_MULTU = 4'b0010,
    MDU_DIV   = 4'b0011,
    MDU_DIVU  = 4'b0100,
    MDU_MTHI  = 4'b0101,
    MDU_MTLO  = 4'b0110
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL_RUN,
    S_DIV_RUN
  } mdu_state_e;

  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;
  localparam int MDU_CNT_W       = 5;

endpackage

// File: rtl/mul_div_unit.sv
// Fixed-latency MIPS-style HI/LO multiply/divide unit: results are computed
// with plain operators from captured operands and retired when the counter expires.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  MDUOp,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  mdu_state_e           state;
  logic [MDU_CNT_W-1:0] cnt;
  logic [31:0]          a_q, b_q;
  logic                 signed_q;

  logic [63:0]        mul_res;
  logic signed [63:0] sa, sb;
  logic [31:0]        div_q, div_r, divisor;
  logic signed [31:0] sq, sr;

  assign Busy = (cnt != '0);

  always_comb begin
    sa      = {{32{a_q[31]}}, a_q};
    sb      = {{32{b_q[31]}}, b_q};
    mul_res = signed_q ? 64'(sa * sb) : ({32'b0, a_q} * {32'b0, b_q});
    // Divide-by-zero never retires, so a dummy divisor keeps the operators defined.
    divisor = (b_q == '0) ? 32'd1 : b_q;
    sq      = $signed(a_q) / $signed(divisor);
    sr      = $signed(a_q) % $signed(divisor);
    if (!signed_q) begin
      div_q = a_q / divisor;
      div_r = a_q % divisor;
    end else if (a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF) begin
      div_q = 32'h8000_0000;
      div_r = '0;
    end else begin
      div_q = sq;
      div_r = sr;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      HI       <= '0;
      LO       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Start && !Busy) begin
            case (mdu_op_e'(MDUOp))
              MDU_MULT, MDU_MULTU: begin
                a_q      <= A;
                b_q      <= B;
                signed_q <= (mdu_op_e'(MDUOp) == MDU_MULT);
                cnt      <= MDU_CNT_W'(MULT_CYCLES);
                state    <= S_MUL_RUN;
              end
              MDU_DIV, MDU_DIVU: begin
                a_q      <= A;
                b_q      <= B;
                signed_q <= (mdu_op_e'(MDUOp) == MDU_DIV);
                cnt      <= MDU_CNT_W'(DIV_CYCLES);
                state    <= S_DIV_RUN;
              end
              MDU_MTHI: HI <= A;
              MDU_MTLO: LO <= A;
              default: ;
            endcase
          end
        end
        S_MUL_RUN: begin
          if (cnt == MDU_CNT_W'(1)) begin
            cnt   <= '0;
            state <= S_IDLE;
            HI    <= mul_res[63:32];
            LO    <= mul_res[31:0];
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DIV_RUN: begin
          if (cnt == MDU_CNT_W'(1)) begin
            cnt   <= '0;
            state <= S_IDLE;
            if (b_q != '0) begin
              HI <= div_r;
              LO <= div_q;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed vector table, random ops
// against an arithmetic reference model, and hand-written corner sequences.
module tb_mul_div_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] A, B;
  logic [3:0]  MDUOp;
  logic        Start;
  logic        Busy;
  logic [31:0] HI, LO;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] m_hi, m_lo;

  mul_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset_n(reset_n), .A(A), .B(B), .MDUOp(MDUOp),
    .Start(Start), .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, hi, lo;
    int          cyc;
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural definitions.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] nhi, output logic [31:0] nlo, output int cyc);
    longint sa, sb, q, r;
    longint unsigned up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    nhi = m_hi; nlo = m_lo; cyc = 0;
    case (op)
      4'd1: begin q = sa * sb; nhi = q[63:32]; nlo = q[31:0]; cyc = MC; end
      4'd2: begin up = {32'b0, a} * {32'b0, b}; nhi = up[63:32]; nlo = up[31:0]; cyc = MC; end
      4'd3: begin
        cyc = DC;
        if (b != 0) begin q = sa / sb; r = sa % sb; nlo = q[31:0]; nhi = r[31:0]; end
      end
      4'd4: begin
        cyc = DC;
        if (b != 0) begin nlo = a / b; nhi = a % b; end
      end
      4'd5: nhi = a;
      4'd6: nlo = a;
      default: ;
    endcase
  endtask

  // Issue at a negedge, scramble operands after acceptance, time Busy, check results.
  task automatic do_op(input string name, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                       input int ecyc);
    int cyc;
    MDUOp = op; A = a; B = b; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0; MDUOp = 4'd0; A = $urandom; B = $urandom;
    cyc = 0;
    @(negedge clk);
    while (Busy && cyc < 64) begin
      chk({name, " hold HI"}, HI, m_hi);
      chk({name, " hold LO"}, LO, m_lo);
      cyc++;
      @(negedge clk);
    end
    chk({name, " busy cycles"}, 32'(cyc), 32'(ecyc));
    chk({name, " HI"}, HI, ehi);
    chk({name, " LO"}, LO, elo);
    m_hi = ehi; m_lo = elo;
  endtask

  initial begin
    logic [31:0] ehi, elo;
    logic [3:0]  op;
    logic [31:0] ra, rb;
    int          ecyc, cyc;

    vt[0]  = '{4'd1, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, MC};
    vt[1]  = '{4'd2, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, MC};
    vt[2]  = '{4'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DC};
    vt[3]  = '{4'd4, 32'd7,        32'd2,        32'h00000001, 32'h00000003, DC};
    vt[4]  = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DC};
    vt[5]  = '{4'd5, 32'h11,       32'd0,        32'h00000011, 32'h80000000, 0};
    vt[6]  = '{4'd6, 32'h22,       32'd0,        32'h00000011, 32'h00000022, 0};
    vt[7]  = '{4'd3, 32'd5,        32'd0,        32'h00000011, 32'h00000022, DC};
    vt[8]  = '{4'd4, 32'd5,        32'd0,        32'h00000011, 32'h00000022, DC};
    vt[9]  = '{4'd5, 32'hDEADBEEF, 32'd0,        32'hDEADBEEF, 32'h00000022, 0};
    vt[10] = '{4'd7, 32'd1,        32'd2,        32'hDEADBEEF, 32'h00000022, 0};
    vt[11] = '{4'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, MC};
    vt[12] = '{4'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DC};

    reset_n = 1'b0; Start = 1'b0; MDUOp = 4'd0; A = '0; B = '0;
    m_hi = '0; m_lo = '0;
    #12;
    chk("reset Busy", {31'b0, Busy}, 32'd0);
    chk("reset HI", HI, 32'd0);
    chk("reset LO", LO, 32'd0);
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);

    // Directed table, issued back-to-back on the first idle cycle.
    for (int i = 0; i < 13; i++)
      do_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].hi, vt[i].lo, vt[i].cyc);

    // Randomized ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(1, 6));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      model(op, ra, rb, ehi, elo, ecyc);
      do_op($sformatf("rnd%0d", i), op, ra, rb, ehi, elo, ecyc);
    end

    // mtlo and a second mult issued while busy must both be ignored.
    MDUOp = 4'd1; A = 32'h1234; B = 32'h10; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0; MDUOp = 4'd0;
    cyc = 0;
    @(negedge clk);
    while (Busy && cyc < 64) begin
      cyc++;
      if (cyc == 2) begin Start = 1'b1; MDUOp = 4'd6; A = 32'd5; end
      else if (cyc == 3) begin Start = 1'b1; MDUOp = 4'd1; A = 32'd1; B = 32'd1; end
      else Start = 1'b0;
      @(negedge clk);
    end
    Start = 1'b0; MDUOp = 4'd0;
    chk("busy-ignore cycles", 32'(cyc), 32'(MC));
    chk("busy-ignore HI", HI, 32'h0);
    chk("busy-ignore LO", LO, 32'h12340);
    @(negedge clk);
    chk("busy-ignore idle after", {31'b0, Busy}, 32'd0);
    m_hi = 32'h0; m_lo = 32'h12340;

    // Reset during busy cycle 3 of a divide aborts with no late write-back.
    MDUOp = 4'd4; A = 32'd100; B = 32'd7; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0; MDUOp = 4'd0;
    repeat (3) @(negedge clk);
    chk("pre-reset Busy", {31'b0, Busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("abort Busy", {31'b0, Busy}, 32'd0);
    chk("abort HI", HI, 32'd0);
    chk("abort LO", LO, 32'd0);
    @(negedge clk); reset_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("post-abort Busy", {31'b0, Busy}, 32'd0);
    chk("post-abort HI", HI, 32'd0);
    chk("post-abort LO", LO, 32'd0);
    m_hi = '0; m_lo = '0;

    // mthi from idle: HI updates next edge, Busy never rises.
    MDUOp = 4'd5; A = 32'hDEADBEEF; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0; MDUOp = 4'd0;
    chk("mthi HI", HI, 32'hDEADBEEF);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("mthi Busy", {31'b0, Busy}, 32'd0);
    end
    chk("mthi LO", LO, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL expose parameter MULT_CYCLES, default 5, meaning Busy-cycle count for mult/multu.
REQ-002 SHALL expose parameter DIV_CYCLES, default 10, meaning Busy-cycle count for div/divu.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port A  input  32  operand rs / mthi-mtlo source.
REQ-006 SHALL have port B  input  32  operand rt.
REQ-007 SHALL have port MDUOp  input  4  0000 none, 0001 mult, 0010 multu, 0011 div, 0100 divu, 0101 mthi, 0110 mtlo, others = none.
REQ-008 SHALL have port Start  input  1  one-cycle issue strobe from the E stage, qualifies MDUOp.
REQ-009 SHALL have port Busy  output  1  operation in flight.
REQ-010 SHALL have port HI  output  32  HI register.
REQ-011 SHALL have port LO  output  32  LO register.

Function
REQ-012 SHALL be idle with Busy=0 until an accepted Start with MDUOp in mult/multu/div/divu.
REQ-013 SHALL accept Start only when Busy=0; Start while Busy=1 ignored, no state change.
REQ-014 SHALL capture A, B, and the op on the accepting edge; later A/B changes have no effect.
REQ-015 SHALL assert Busy from the edge after acceptance for exactly MULT_CYCLES (mult/multu) or DIV_CYCLES (div/divu) cycles, then deassert.
REQ-016 SHALL update HI/LO on the same edge Busy falls; HI/LO hold old values while Busy=1.
REQ-017 SHALL compute mult as signed 32x32->64 {HI,LO}; multu unsigned.
REQ-018 SHALL compute div: LO = signed quotient truncated toward zero, HI = remainder with dividend's sign; divu unsigned.
REQ-019 SHALL, for div 0x80000000 / 0xFFFFFFFF, give LO=0x80000000, HI=0.
REQ-020 SHALL, for B=0 on div/divu, still run full DIV_CYCLES Busy, then leave HI/LO unchanged.
REQ-021 SHALL, for mthi/mtlo with Start and Busy=0, write A to HI/LO on that edge, Busy stays 0.
REQ-022 SHALL ignore mthi/mtlo while Busy=1.
REQ-023 SHALL use a down-counter loaded with cycle count on acceptance; Busy = (counter != 0).
REQ-024 SHALL accept a new Start on the first cycle Busy=0 after completion (back-to-back allowed).
REQ-025 SHALL define FSM IDLE -> MUL_RUN/DIV_RUN on accept -> IDLE at counter 1->0.
REQ-026 SHALL allow parameter values 1..31; counter width 5 bits.

Reset
REQ-027 SHALL, on reset_n low, asynchronously clear HI=0, LO=0, Busy=0, counter=0, FSM=IDLE.
REQ-028 SHALL abort any in-flight operation on reset without updating HI/LO.
REQ-029 SHALL ignore Start on the first edge after reset_n rises only if reset_n is low at that edge.

Structure
REQ-030 SHALL place MDUOp encodings and default cycle counts in shared package mdu_pkg.
REQ-031 SHALL be one module; no sub-module; result computed with operators, latency by counter.
REQ-032 SHALL be stalled externally by hazard unit using (Start | Busy) for mfhi/mflo/MDU ops.

Verification
REQ-033 SHALL cover: mult A=0xFFFFFFFF, B=2 -> Busy 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; multu same -> HI=1, LO=0xFFFFFFFE.
REQ-034 SHALL cover: div A=-7, B=2 -> Busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7, B=2 -> LO=3, HI=1.
REQ-035 SHALL cover: div B=0 with HI=0x11, LO=0x22 -> Busy 10 cycles, HI=0x11, LO=0x22.
REQ-036 SHALL cover: Start mult then Start mtlo A=5 at Busy cycle 2 -> mtlo ignored, LO = mult result.
REQ-037 SHALL cover: reset_n low at Busy cycle 3 of div -> Busy=0, HI=LO=0 immediately, no later update.
REQ-038 SHALL cover: mthi A=0xDEADBEEF, Busy=0 -> HI=0xDEADBEEF next edge, Busy never rises.
